// File: rtl/vec_addsub_pkg.sv
// frodo_pkg: shared encodings, FSM state type and default width for the FrodoKEM vector engines
package frodo_pkg;
    localparam int DEF_WIDTH = 16;
    localparam logic [2:0] SEC_L1 = 3'b001;
    localparam logic [2:0] SEC_L3 = 3'b011;
    localparam logic [2:0] SEC_L5 = 3'b101;
    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/vec_addsub_if.sv
// vec_addsub_if: burst control, input beat and output beat signals of the vector add/sub engine
interface vec_addsub_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 4,
    parameter int CNT_W = 16
);
    logic                   i_start;
    logic [2:0]             i_sec_lev;
    logic                   i_op;
    logic [CNT_W-1:0]       i_len;
    logic                   i_valid;
    logic                   o_ready;
    logic [LANES*WIDTH-1:0] i_a;
    logic [LANES*WIDTH-1:0] i_b;
    logic                   o_valid;
    logic                   i_ready;
    logic [LANES*WIDTH-1:0] o_c;
    logic                   o_last;
    logic                   o_done;
    logic                   o_busy;

    modport master (
        output i_start, i_sec_lev, i_op, i_len, i_valid, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_c, o_last, o_done, o_busy
    );

    modport slave (
        input  i_start, i_sec_lev, i_op, i_len, i_valid, i_a, i_b, i_ready,
        output o_ready, o_valid, o_c, o_last, o_done, o_busy
    );
endinterface

// File: rtl/vec_addsub_lane.sv
// lane_addsub: one combinational lane of modular add/sub with level-1 top-bit masking
module lane_addsub
    import frodo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             l1,
    output logic [WIDTH-1:0] c
);
    // q is a power of two, so dropping the carry/borrow out of the top bit is the full reduction
    always_comb c = ((op == OP_ADD) ? a + b : a - b) & {~l1, {(WIDTH-1){1'b1}}};
endmodule

// File: rtl/vec_addsub.sv
// vec_addsub: burst FSM, beat counter and stallable pipeline; VEC_ADDSUB_OREG_EN adds an output stage
module vec_addsub
    import frodo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input logic         i_clk,
    input logic         i_rst,
    vec_addsub_if.slave bus
);
    localparam int DW = LANES * WIDTH;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             lvl1_q, lvl1_d;
    logic             op_q, op_d;
    logic             done_q, done_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q, s1_last_d;
    logic [DW-1:0]    s1_c_q, s1_c_d;
    logic [DW-1:0]    res;
    logic             out_valid, out_last, advance, ready, in_hs;
    logic [DW-1:0]    out_c;

    for (genvar k = 0; k < LANES; k++) begin : gen_lane
        lane_addsub #(.WIDTH(WIDTH)) u_lane (
            .a  (bus.i_a[k*WIDTH +: WIDTH]),
            .b  (bus.i_b[k*WIDTH +: WIDTH]),
            .op (op_q),
            .l1 (lvl1_q),
            .c  (res[k*WIDTH +: WIDTH])
        );
    end

    // Handshake, burst FSM next state and first pipeline stage
    always_comb begin
        advance    = !out_valid || bus.i_ready;
        ready      = (state_q == RUN) && (rem_q != '0) && advance;
        in_hs      = bus.i_valid && ready;
        state_d    = state_q;
        rem_d      = rem_q;
        lvl1_d     = lvl1_q;
        op_d       = op_q;
        done_d     = 1'b0;
        s1_valid_d = advance ? in_hs : s1_valid_q;
        s1_last_d  = advance ? (in_hs && rem_q == CNT_W'(1)) : s1_last_q;
        s1_c_d     = in_hs ? res : s1_c_q;
        case (state_q)
            IDLE: if (bus.i_start) begin
                lvl1_d  = (bus.i_sec_lev == SEC_L1);
                op_d    = bus.i_op;
                rem_d   = bus.i_len;
                done_d  = (bus.i_len == '0);
                state_d = (bus.i_len == '0) ? IDLE : RUN;
            end
            RUN: if (in_hs) begin
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q == CNT_W'(1)) ? DRAIN : RUN;
            end
            DRAIN: if (out_valid && bus.i_ready && out_last) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and first pipeline stage registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            lvl1_q     <= 1'b0;
            op_q       <= 1'b0;
            done_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_c_q     <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            lvl1_q     <= lvl1_d;
            op_q       <= op_d;
            done_q     <= done_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_c_q     <= s1_c_d;
        end
    end

`ifdef VEC_ADDSUB_OREG_EN
    logic          s2_valid_q, s2_valid_d;
    logic          s2_last_q, s2_last_d;
    logic [DW-1:0] s2_c_q, s2_c_d;

    // Output stage takes whatever stage 1 holds whenever the pipeline advances
    always_comb begin
        s2_valid_d = advance ? s1_valid_q : s2_valid_q;
        s2_last_d  = advance ? s1_last_q : s2_last_q;
        s2_c_d     = (advance && s1_valid_q) ? s1_c_q : s2_c_q;
    end

    // Output stage registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_c_q     <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_c_q     <= s2_c_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_last  = s2_last_q;
    assign out_c     = s2_c_q;
`else
    assign out_valid = s1_valid_q;
    assign out_last  = s1_last_q;
    assign out_c     = s1_c_q;
`endif

    assign bus.o_ready = ready;
    assign bus.o_valid = out_valid;
    assign bus.o_last  = out_last;
    assign bus.o_c     = out_c;
    assign bus.o_done  = done_q;
    assign bus.o_busy  = (state_q != IDLE);
endmodule

// File: tb/tb_vec_addsub.sv
// tb_vec_addsub: randomized and directed checks of vec_addsub against a modular-arithmetic model
module tb_vec_addsub;
    localparam int W = 16;
    localparam int L = 4;
    localparam int C = 16;
`ifdef VEC_ADDSUB_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [L*W-1:0] exp_c_q[$];
    bit             exp_l_q[$];
    logic [L*W-1:0] prev_c;
    logic           prev_last;
    bit             prev_stall = 0;

    vec_addsub_if #(.WIDTH(W), .LANES(L), .CNT_W(C)) bus();

    vec_addsub #(.WIDTH(W), .LANES(L), .CNT_W(C)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected result: each lane reduced mod q, q = 2^15 at level 1 and 2^16 otherwise
    function automatic logic [L*W-1:0] ref_vec(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                               input logic op, input logic [2:0] sec);
        logic [L*W-1:0] r;
        int q = (sec == 3'b001) ? 32768 : 65536;
        for (int k = 0; k < L; k++) begin
            int x = int'(a[k*W +: W]) % q;
            int y = int'(b[k*W +: W]) % q;
            int z = op ? (x + y) % q : (x - y + q) % q;
            r[k*W +: W] = W'(z);
        end
        return r;
    endfunction

    // Output monitor: scoreboard on every output handshake, hold and ready checks while stalled
    always @(negedge clk) begin
        logic [L*W-1:0] ec;
        bit             el;
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (bus.o_valid !== 1'b1 || bus.o_c !== prev_c || bus.o_last !== prev_last) begin
                    errors++;
                    $display("FAIL hold: valid=%b c=%h last=%b required valid=1 c=%h last=%b",
                             bus.o_valid, bus.o_c, bus.o_last, prev_c, prev_last);
                end
            end
            if (bus.o_valid && !bus.i_ready) begin
                checks++;
                if (bus.o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_ready: o_ready=%b required 0", bus.o_ready);
                end
            end
            if (bus.o_valid && bus.i_ready) begin
                checks++;
                if (exp_c_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: c=%h required no beat", bus.o_c);
                end else begin
                    ec = exp_c_q.pop_front();
                    el = exp_l_q.pop_front();
                    if (bus.o_c !== ec || bus.o_last !== el) begin
                        errors++;
                        $display("FAIL beat: c=%h last=%b required c=%h last=%b", bus.o_c, bus.o_last, ec, el);
                    end
                end
            end
            prev_stall = bus.o_valid && !bus.i_ready;
            prev_c     = bus.o_c;
            prev_last  = bus.o_last;
        end
    end

    // One burst; mode 0 = free flow, 1 = ready low 3 cycles after 2nd output, 2 = random valid/ready
    task automatic burst(input logic op, input logic [2:0] sec, input int len, input int mode, input bit poke,
                         input bit fixed, input logic [W-1:0] fa, input logic [W-1:0] fb,
                         input logic [W-1:0] fe, input string name);
        int             sent = 0;
        int             outs = 0;
        int             stall = 0;
        int             cyc = 0;
        int             first = -1;
        int             last_out = -1;
        bit             done = 0;
        logic [L*W-1:0] e;
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_op = op; bus.i_sec_lev = sec; bus.i_len = C'(len);
        bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0; bus.i_op = ~op; bus.i_sec_lev = (sec == 3'b001) ? 3'b101 : 3'b001;
        bus.i_len = C'(len + 3);
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_rise: o_busy=%b required 1", name, bus.o_busy);
        end
        while (!done && cyc < 400) begin
            bus.i_start = poke && cyc < 2;
            bus.i_ready = (mode == 1) ? (stall == 0) : (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (stall > 0) stall--;
            bus.i_valid = (sent < len) && (mode != 2 || $urandom_range(0, 3) != 0);
            if (fixed) begin
                bus.i_a = {L{fa}};
                bus.i_b = {L{fb}};
            end else begin
                bus.i_a = {$urandom, $urandom};
                bus.i_b = {$urandom, $urandom};
            end
            @(negedge clk);
            if (bus.i_valid && bus.o_ready) begin
                e = fixed ? {L{fe}} : ref_vec(bus.i_a, bus.i_b, op, sec);
                sent++;
                exp_c_q.push_back(e);
                exp_l_q.push_back(sent == len);
                if (first < 0) first = cyc;
            end
            if (bus.o_valid && bus.i_ready) begin
                outs++;
                last_out = cyc;
                if (mode == 1 && outs == 2) stall = 3;
            end
            if (bus.o_done) begin
                done = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        bus.i_start = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: no o_done after %0d cycles, sent %0d of %0d", name, cyc, sent, len);
        end else begin
            checks++;
            if (sent != len || outs != len || exp_c_q.size() != 0) begin
                errors++;
                $display("FAIL %s count: in=%0d out=%0d pending=%0d required %0d/%0d/0",
                         name, sent, outs, exp_c_q.size(), len, len);
            end
            checks++;
            if (bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_fall: o_busy=%b with o_done required 0", name, bus.o_busy);
            end
            checks++;
            if (cyc != last_out + 1) begin
                errors++;
                $display("FAIL %s done_time: done cycle %0d required %0d", name, cyc, last_out + 1);
            end
            if (mode == 0) begin
                checks++;
                if (cyc != first + len + LAT) begin
                    errors++;
                    $display("FAIL %s throughput: done cycle %0d required %0d", name, cyc, first + len + LAT);
                end
            end
        end
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: o_done=%b one cycle later required 0", name, bus.o_done);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.o_valid, bus.o_last, bus.o_done, bus.o_busy, bus.o_ready, bus.o_c} !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b last=%b done=%b busy=%b ready=%b c=%h required all 0",
                     bus.o_valid, bus.o_last, bus.o_done, bus.o_busy, bus.o_ready, bus.o_c);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_borrow();
        burst(1'b0, 3'b101, 1, 0, 0, 1, 16'h0003, 16'h0005, 16'hFFFE, "borrow_l5");
        burst(1'b0, 3'b001, 1, 0, 0, 1, 16'h0003, 16'h0005, 16'h7FFE, "borrow_l1");
    endtask

    task automatic test_add_wrap();
        burst(1'b1, 3'b101, 1, 0, 0, 1, 16'hFFFF, 16'h0002, 16'h0001, "wrap_l5");
        burst(1'b1, 3'b001, 1, 0, 0, 1, 16'h7FFF, 16'h0001, 16'h0000, "wrap_l1");
        burst(1'b1, 3'b001, 1, 0, 0, 1, 16'hFFFF, 16'h0000, 16'h7FFF, "msb_l1");
        burst(1'b1, 3'b011, 1, 0, 0, 1, 16'h8001, 16'h8001, 16'h0002, "wrap_l3");
    endtask

    task automatic test_streaming();
        burst(1'b1, 3'b101, 4, 0, 0, 0, '0, '0, '0, "stream_add");
        burst(1'b0, 3'b001, 4, 0, 0, 0, '0, '0, '0, "stream_sub_l1");
    endtask

    task automatic test_backpressure();
        burst(1'b0, 3'b011, 6, 1, 0, 0, '0, '0, '0, "backpressure");
    endtask

    task automatic test_zero_len();
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_len = '0; bus.i_op = 1'b1; bus.i_sec_lev = 3'b101; bus.i_valid = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: done=%b busy=%b valid=%b required 1/0/0", bus.o_done, bus.o_busy, bus.o_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_done !== 1'b0 || bus.o_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_len_after: done=%b valid=%b required 0/0", bus.o_done, bus.o_valid);
            end
        end
    endtask

    task automatic test_ignored_start();
        burst(1'b1, 3'b101, 3, 0, 1, 0, '0, '0, '0, "ignored_start");
    endtask

    task automatic test_reset_mid();
        int sent = 0;
        int cyc = 0;
        @(posedge clk); #1;
        bus.i_start = 1'b1; bus.i_len = C'(5); bus.i_op = 1'b1; bus.i_sec_lev = 3'b101;
        bus.i_ready = 1'b1; bus.i_valid = 1'b0;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        while (sent < 2 && cyc < 50) begin
            bus.i_valid = 1'b1;
            bus.i_a = {$urandom, $urandom};
            bus.i_b = {$urandom, $urandom};
            @(negedge clk);
            if (bus.o_ready) begin
                sent++;
                exp_c_q.push_back(ref_vec(bus.i_a, bus.i_b, 1'b1, 3'b101));
                exp_l_q.push_back(1'b0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        rst = 1'b1;
        bus.i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.o_valid, bus.o_last, bus.o_done, bus.o_busy, bus.o_ready, bus.o_c} !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b last=%b done=%b busy=%b ready=%b c=%h required all 0",
                     bus.o_valid, bus.o_last, bus.o_done, bus.o_busy, bus.o_ready, bus.o_c);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_c_q.delete();
        exp_l_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_done !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_abort: done=%b valid=%b busy=%b required 0/0/0",
                         bus.o_done, bus.o_valid, bus.o_busy);
            end
        end
        burst(1'b0, 3'b101, 2, 0, 0, 0, '0, '0, '0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            burst(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), int'($urandom_range(1, 8)), 2, 0, 0,
                  '0, '0, '0, "random");
        end
    endtask

    initial begin
        bus.i_start = 1'b0; bus.i_sec_lev = '0; bus.i_op = 1'b0; bus.i_len = '0;
        bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.i_a = '0; bus.i_b = '0;
        test_reset();
        test_borrow();
        test_add_wrap();
        test_streaming();
        test_backpressure();
        test_zero_len();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vec_addsub.md
# vec_addsub

Multi-lane, pipelined modular add/subtract engine for FrodoKEM matrix arithmetic. Processes bursts of `LANES` coefficients per beat under a valid/ready handshake and reduces each result mod q, where q = 2^(WIDTH-1) at security level 1 and 2^WIDTH at every other level. Sits between the coefficient memories and the sampler/encode datapath. It runs the whole-vector additions and subtractions in key generation, encapsulation and decapsulation, with a burst length counter and a completion pulse for the top-level controller.

## Interface
- `WIDTH`, 16, coefficient width in bits
- `LANES`, 4, coefficients processed per beat
- `CNT_W`, 16, width of the burst length counter

- `i_clk` in 1, clock
- `i_rst` in 1, reset; one clock; reset is synchronous and active-high
- `i_start` in 1, begin a burst; sampled only in IDLE
- `i_sec_lev` in 3, security level; 3'b001 = level 1, any other value = level 3/5 modulus; latched at start
- `i_op` in 1, 0 = subtract (a − b), 1 = add (a + b); latched at start
- `i_len` in CNT_W, number of beats in the burst; latched at start
- `i_valid` in 1, input beat valid
- `o_ready` out 1, engine accepts a beat this cycle
- `i_a`, `i_b` in LANES*WIDTH, packed operands; lane k is bits [k*WIDTH +: WIDTH]
- `o_valid` out 1, output beat valid
- `i_ready` in 1, downstream accepts output
- `o_c` out LANES*WIDTH, packed results
- `o_last` out 1, qualifies the final beat of the burst
- `o_done` out 1, one-cycle pulse when the burst is completely drained
- `o_busy` out 1, state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - On `i_start`, latch `i_sec_lev`, `i_op` and `i_len`, and load `remaining = i_len`.
  - If `i_len` = 0: pulse `o_done` the next cycle and stay in IDLE.
  - Otherwise go to RUN.
- RUN:
  - `o_ready = (remaining ≠ 0) && advance`, where `advance = !o_valid || i_ready`.
  - Each input handshake (`i_valid && o_ready`) decrements `remaining` and pushes one beat into the pipeline, tagged last when `remaining` = 1.
  - When the last beat is accepted, go to DRAIN.
- DRAIN:
  - `o_ready` = 0.
  - When the output handshake of the beat tagged last completes, pulse `o_done` the next cycle and go to IDLE.
- Per-lane arithmetic, using `WIDTH+1`-bit intermediates:
  - Subtract: `t = {0,a} − {0,b}`. Add: `t = {0,a} + {0,b}`.
  - Result is `t[WIDTH-1:0]`. At level 1, bit `WIDTH-1` is also forced to 0.
  - This is exact mod q, because q is a power of two and a borrow/carry is absorbed by truncation.
  - At level 1, operand bit `WIDTH-1` therefore has no effect on the result.
- `i_start` while busy is ignored. `i_sec_lev` and `i_op` changes mid-burst are ignored.
- Pipeline is fully stallable: every stage register loads only when `advance` = 1. No beat is dropped or duplicated under any `i_ready` pattern.
- `o_c` and `o_last` hold stable while `o_valid && !i_ready`.
- Reset mid-burst aborts the burst. No `o_done` is produced for the aborted burst.

## Timing
- Reset values: `o_valid`, `o_last`, `o_done`, `o_busy`, `o_ready` = 0; `o_c` = 0; state IDLE; `remaining` = 0.
- Latency from input handshake to `o_valid` is 1 cycle (2 with `VEC_ADDSUB_OREG_EN`).
- Throughput is one beat per cycle when `i_valid` and `i_ready` are both held high.
- `o_busy` rises the cycle after `i_start` and falls in the same cycle that `o_done` is asserted.
- Back-to-back bursts: `i_start` is accepted in the cycle `o_done` is high, because the FSM is already back in IDLE.

## Configuration
- `VEC_ADDSUB_OREG_EN` defined:
  - Adds a second, stallable register stage after the arithmetic, for timing closure at the target frequency.
  - Latency becomes 2 cycles.
- Undefined:
  - Single stage; latency is 1 cycle.
- Handshake, `o_last` and `o_done` semantics are identical in both builds.

## Structure
- Shared package `frodo_pkg`:
  - Security-level encodings (`SEC_L1` = 3'b001, `SEC_L3`, `SEC_L5`)
  - Opcode constants (`OP_SUB`, `OP_ADD`)
  - The FSM state typedef
  - Default `WIDTH`
- Sub-module `lane_addsub`: purely combinational, one lane of add/sub plus level-1 masking. It is generated `LANES` times.
- `vec_addsub` holds only the FSM, the burst counter and the pipeline registers.

## Test plan
- Level-5 subtract borrow:
  - Stimulus: a = 0x0003, b = 0x0005 on every lane, `i_len` = 1.
  - Required: `o_c` lanes = 0xFFFE, `o_last` = 1, `o_done` pulses once.
  - Same beat at level 1 (3'b001): lanes = 0x7FFE.
- Add wrap:
  - Level 5: a = 0xFFFF, b = 0x0002 gives 0x0001.
  - Level 1: a = 0x7FFF, b = 0x0001 gives 0x0000.
  - Level 1: a = 0xFFFF, b = 0x0000 gives 0x7FFF.
- Streaming:
  - Stimulus: `i_len` = 4, `i_valid` and `i_ready` held high, distinct per-lane data.
  - Required: 4 consecutive output beats in order, `o_last` only on the 4th, `o_done` the cycle after the 4th handshake.
- Backpressure:
  - Stimulus: `i_len` = 6, `i_ready` low for 3 cycles after beat 2.
  - Required: `o_c` held stable, `o_ready` low while stalled, all 6 results correct with no loss or duplication.
- Zero length and ignored start:
  - `i_len` = 0 gives an `o_done` pulse one cycle after `i_start` and no `o_valid`.
  - `i_start` asserted mid-burst leaves `remaining` and the latched operation unchanged.
- Reset mid-burst:
  - Stimulus: `i_rst` asserted after 2 of 5 beats.
  - Required: all outputs 0 the next cycle, no `o_done`.
  - A fresh burst with `i_len` = 2 completes correctly afterwards.
